dmem_responder: RTL and testbench

- Data-memory responder on the core's data-side port.
- Services the core's mem_read / mem_write requests against an internal word array.
  - Adds a configurable wait-state count.
  - Uses an explicit completion handshake.
- Lets the datapath run against slow memory models and later a cache/bus bridge.
- Sits between the core's dmem_* outputs and its dmem_read_data input.

---
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the core's data-side port. Serves mem_read and
// mem_write requests from an internal word array. A configurable number of
// wait states is inserted between acceptance and completion, and ready
// signals completion with a one-cycle pulse.
//
// Parameters:
//   DEPTH       - number of 32-bit words stored; word index = dmem_addr[31:2]
//   WAIT_STATES - extra cycles between acceptance and completion (0..15)
//
// Ports:
//   clock           - single clock, all state on the rising edge
//   reset           - asynchronous, active-low reset
//   mem_read        - read request, held by the initiator until ready
//   mem_write       - write request, held by the initiator until ready
//   dmem_addr       - byte address, held with the request
//   dmem_write_data - write data, held with the request
//   dmem_read_data  - registered read data, valid when ready=1 after a read
//   ready           - one-cycle completion pulse
//   busy            - high from acceptance through the completion cycle
//   error           - one-cycle pulse with ready on a faulted access
//
// Optional build macro: DMEM_ALIGN_CHECK_EN. When it is defined, an address
// with dmem_addr[1:0] != 0 at acceptance is treated as a faulted access.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  output logic [31:0] dmem_read_data,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);
  // Byte-address limit: addr >= DEPTH*4 is the same as word index >= DEPTH.
  localparam logic [31:0] LIMIT   = 32'(DEPTH * 4);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Classifies a request as faulted (conflicting op, out of range, misaligned).
  function automatic logic access_fault(input logic        rd,
                                        input logic        wr,
                                        input logic [31:0] addr);
    logic f;
    f = (rd & wr) | (addr >= LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    f = f | (addr[1:0] != 2'b00);
`endif
    return f;
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic [3:0]    cnt_r;
  logic          rd_r;
  logic          wr_r;
  logic          fault_r;
  logic [AW-1:0] idx_r;
  logic [31:0]   wdata_r;

  logic          rd_s;
  logic          wr_s;
  logic          fault_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   wdata_s;
  logic          commit_s;
  logic          do_write_s;
  logic          do_read_s;

  logic [31:0]   rdata_r;
  logic          ready_r;
  logic          busy_r;
  logic          error_r;

  logic [31:0]   mem_r [0:DEPTH-1];

  // Next-state logic for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (mem_read | mem_write) begin
          next_state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // <= 1 instead of == 1 so a corrupted zero count cannot stall here.
        if (cnt_r <= 4'd1) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Commit operands: with zero wait states completion happens on the
  // acceptance edge, so the live inputs are used in IDLE and the latched
  // copy everywhere else.
  always_comb begin
    if (state_r == ST_IDLE) begin
      rd_s    = mem_read;
      wr_s    = mem_write;
      fault_s = access_fault(mem_read, mem_write, dmem_addr);
      idx_s   = dmem_addr[AW+1:2];
      wdata_s = dmem_write_data;
    end else begin
      rd_s    = rd_r;
      wr_s    = wr_r;
      fault_s = fault_r;
      idx_s   = idx_r;
      wdata_s = wdata_r;
    end
  end

  assign commit_s   = (next_state_s == ST_DONE);
  assign do_write_s = commit_s & wr_s & ~fault_s;
  assign do_read_s  = commit_s & rd_s & ~fault_s;

  // Word array write port; contents survive reset, but no write lands while
  // reset is asserted.
  always_ff @(posedge clock) begin
    if (reset && do_write_s) begin
      mem_r[idx_s] <= wdata_s;
    end
  end

  // Sequencer state, wait counter, latched request and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      fault_r <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_IDLE: begin
          if (mem_read | mem_write) begin
            rd_r    <= mem_read;
            wr_r    <= mem_write;
            fault_r <= fault_s;
            idx_r   <= idx_s;
            wdata_r <= dmem_write_data;
            cnt_r   <= WS_INIT;
          end
        end
        ST_WAIT: cnt_r <= cnt_r - 4'd1;
        ST_DONE: cnt_r <= 4'd0;
        default: cnt_r <= 4'd0;
      endcase
      ready_r <= commit_s;
      error_r <= commit_s & fault_s;
      busy_r  <= (next_state_s != ST_IDLE);
      // Read data only moves on a successful read; writes and faults keep it.
      if (do_read_s) begin
        rdata_r <= mem_r[idx_s];
      end
    end
  end

  assign dmem_read_data = rdata_r;
  assign ready          = ready_r;
  assign busy           = busy_r;
  assign error          = error_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none. Each transaction pushes its expected error/read-data pair
// into a queue when driven; the pair is popped when ready is seen.
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        rd2 = 1'b0, wr2 = 1'b0;
  logic [31:0] addr2 = 32'd0, wdata2 = 32'd0;
  logic [31:0] rdata2;
  logic        ready2, busy2, error2;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0, busy0, error0;

  int checks = 0;
  int errors = 0;

  exp_t        sb_q[$];
  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  logic [31:0] last2 = 32'd0;
  logic [31:0] last0 = 32'd0;

  dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset),
    .mem_read(rd2), .mem_write(wr2),
    .dmem_addr(addr2), .dmem_write_data(wdata2),
    .dmem_read_data(rdata2), .ready(ready2), .busy(busy2), .error(error2)
  );

  dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .mem_read(rd0), .mem_write(wr0),
    .dmem_addr(addr0), .dmem_write_data(wdata0),
    .dmem_read_data(rdata0), .ready(ready0), .busy(busy0), .error(error0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance sel (0: two wait states, 1: none).
  task automatic txn(input bit sel, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data,
                     input bit perturb);
    logic f;
    int   w;
    int   ws;
    int   lat;
    exp_t e;
    ws = sel ? 0 : 2;
    w  = int'(addr[31:2]);
    f  = (rd & wr) | (addr >= 32'h0000_0400);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) f = 1'b1;
`endif
    if (!f && wr) begin
      if (sel) m0[w] = data; else m2[w] = data;
    end
    if (!f && rd) begin
      if (sel) last0 = m0[w]; else last2 = m2[w];
    end
    e.err   = f;
    e.rdata = sel ? last0 : last2;
    sb_q.push_back(e);

    if (sel) begin rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data; end
    else     begin rd2 = rd; wr2 = wr; addr2 = addr; wdata2 = data; end

    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      check("busy_in_txn", {31'd0, (sel ? busy0 : busy2)}, 32'd1);
      if (perturb && lat == 1) begin
        // Inputs are ignored outside IDLE; the latched copy must be used.
        addr2 = 32'h0000_0020; wdata2 = 32'h0000_0000;
      end
    end while (!(sel ? ready0 : ready2) && lat < 20);

    check("latency", lat, ws + 1);
    e = sb_q.pop_front();
    check("error_with_ready", {31'd0, (sel ? error0 : error2)}, {31'd0, e.err});
    check("read_data", sel ? rdata0 : rdata2, e.rdata);

    if (sel) begin rd0 = 1'b0; wr0 = 1'b0; end
    else     begin rd2 = 1'b0; wr2 = 1'b0; end

    @(negedge clock);
    check("ready_after", {31'd0, (sel ? ready0 : ready2)}, 32'd0);
    check("busy_after",  {31'd0, (sel ? busy0 : busy2)},  32'd0);
    check("error_after", {31'd0, (sel ? error0 : error2)}, 32'd0);
  endtask

  initial begin
    // Reset held for three cycles.
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_ready2", {31'd0, ready2}, 32'd0);
    check("rst_busy2",  {31'd0, busy2},  32'd0);
    check("rst_error2", {31'd0, error2}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_busy0",  {31'd0, busy0},  32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Write then read back, two wait states.
    txn(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
    // Out-of-range read and simultaneous read/write are faults.
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b0);
    txn(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
    // Last valid word, with inputs disturbed during WAIT.
    txn(1'b0, 1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_0FF0, 1'b1);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0);
    txn(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0);

    // Reset during WAIT aborts the write and suppresses ready.
    rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'h0000_0020; wdata2 = 32'hCAFE_F00D;
    @(negedge clock);
    check("abort_busy", {31'd0, busy2}, 32'd1);
    reset = 1'b0;
    wr2 = 1'b0;
    last2 = 32'd0;
    last0 = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_no_ready", {31'd0, ready2}, 32'd0);
    end
    check("abort_rdata", rdata2, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);

    // Misaligned write; the model decides per build.
    txn(1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h0000_AAAA, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0);

    // Zero wait states.
    txn(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0);
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
